// File: rtl/serial_mac.sv
// Shift-and-add serial multiply-accumulate: one multiplier bit per clock, run-time
// per-operand signedness, optional accumulation into a guard-extended accumulator.
module serial_mac #(
    parameter  int A_WIDTH   = 8,
    parameter  int B_WIDTH   = 8,
    parameter  int GUARD     = 4,
    parameter  int OUT_SHIFT = 0,
    localparam int ACC_WIDTH = A_WIDTH + B_WIDTH + GUARD,
    localparam int OUT_WIDTH = ACC_WIDTH - OUT_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic                 accumulate,
    input  logic                 clear,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] out
);

    localparam int CNT_W = $clog2(B_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   mcand_q, mcand_d;
    logic [B_WIDTH-1:0]     b_q, b_d;
    logic                   b_signed_q, b_signed_d;
    logic                   accum_q, accum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   pp_q, pp_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   done_q, done_d;

    logic                   last_bit;
    logic [ACC_WIDTH-1:0]   addend;
    logic [ACC_WIDTH-1:0]   pp_sum;

    // NOTE: every signal gets its default before any branch, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        b_d        = b_q;
        b_signed_d = b_signed_q;
        accum_d    = accum_q;
        cnt_d      = cnt_q;
        pp_d       = pp_q;
        acc_d      = acc_q;
        done_d     = 1'b0;

        last_bit = (cnt_q == CNT_W'(B_WIDTH - 1));
        addend   = b_q[0] ? mcand_q : '0;
        // The MSB of a two's-complement multiplier carries negative weight.
        pp_sum   = (last_bit && b_signed_q) ? pp_q - addend : pp_q + addend;

        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    acc_d = '0;
                end
                if (start) begin
                    mcand_d    = {{(ACC_WIDTH - A_WIDTH){a_signed & a[A_WIDTH-1]}}, a};
                    b_d        = b;
                    b_signed_d = b_signed;
                    accum_d    = accumulate;
                    cnt_d      = '0;
                    pp_d       = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Shifting the multiplicand left and the multiplier right each cycle
                // replaces a variable shifter and bit-select mux.
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                pp_d    = pp_sum;
                if (last_bit) begin
                    acc_d   = (accum_q ? acc_q : '0) + pp_sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            b_q        <= '0;
            b_signed_q <= 1'b0;
            accum_q    <= 1'b0;
            cnt_q      <= '0;
            pp_q       <= '0;
            acc_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            b_q        <= b_d;
            b_signed_q <= b_signed_d;
            accum_q    <= accum_d;
            cnt_q      <= cnt_d;
            pp_q       <= pp_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign out  = acc_q[ACC_WIDTH-1:OUT_SHIFT];

endmodule

// File: tb/tb_serial_mac.sv
// Self-checking bench for serial_mac (4x4, 4 guard bits) plus an OUT_SHIFT=2 instance;
// expected results are queued at start and compared when done pulses.
module tb_serial_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        a_signed;
    logic        b_signed;
    logic        accumulate;
    logic        clear;
    logic        busy, busy2;
    logic        done, done2;
    logic [11:0] out;
    logic [9:0]  out2;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int acc_m    = 0;

    serial_mac #(.A_WIDTH(4), .B_WIDTH(4), .GUARD(4), .OUT_SHIFT(0)) u_mac (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .a_signed(a_signed), .b_signed(b_signed), .accumulate(accumulate),
        .clear(clear), .busy(busy), .done(done), .out(out)
    );

    serial_mac #(.A_WIDTH(4), .B_WIDTH(4), .GUARD(4), .OUT_SHIFT(2)) u_mac_trunc (
        .clk(clk), .reset(reset), .start(start2), .a(a), .b(b),
        .a_signed(a_signed), .b_signed(b_signed), .accumulate(accumulate),
        .clear(clear), .busy(busy2), .done(done2), .out(out2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    function automatic int ref_prod(input logic [3:0] x, input logic [3:0] y,
                                    input logic xs, input logic ys);
        int xv, yv;
        if (xs) xv = int'($signed(x)); else xv = int'(x);
        if (ys) yv = int'($signed(y)); else yv = int'(y);
        return xv * yv;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one op on u_mac, then checks busy length, latency and the result.
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic as,
                          input logic bs, input logic acc, input logic clr, input string tag);
        int n;
        int bcnt;
        if (clr) acc_m = 0;
        acc_m = ((acc ? acc_m : 0) + ref_prod(ai, bi, as, bs)) & 'hFFF;
        exp_q.push_back(acc_m);
        a = ai; b = bi; a_signed = as; b_signed = bs;
        accumulate = acc; clear = clr; start = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        bcnt = 1;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (busy) bcnt++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_busy_cycles"}, bcnt, 4);
        check({tag, "_busy_at_done"}, busy, 0);
        pop_check({tag, "_out"}, out);
    endtask

    initial begin
        int n;
        int done_seen;

        reset = 1'b1; start = 1'b0; start2 = 1'b0; a = '0; b = '0;
        a_signed = 1'b0; b_signed = 1'b0; accumulate = 1'b0; clear = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", out, 0);
        check("reset_out_trunc", out2, 0);
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        run_op(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "u15x15");
        check("u15x15_const", out, 'h0E1);

        run_op(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, "s_m8xm8");
        check("s_m8xm8_const", out, 'h040);
        run_op(4'h8, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, "s_m8x7");
        check("s_m8x7_const", out, 'hFC8);
        run_op(4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, "s_m1xm1");
        check("s_m1xm1_const", out, 'h001);

        run_op(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, "mix_15xm1");
        check("mix_15xm1_const", out, 'hFF1);
        run_op(4'h8, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, "mix_m8x15");
        check("mix_m8x15_const", out, 'hF88);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_op(4'(i), 4'(j), 1'b0, 1'b0, 1'b0, 1'b0, "sweep_u");
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_op(4'(i), 4'(j), 1'b1, 1'b1, 1'b0, 1'b0, "sweep_s");

        run_op(4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, "clr_acc_3x5");
        check("clr_acc_3x5_const", out, 'h00F);

        // 2*7 accumulating, with start/clear/operand changes while busy.
        acc_m = (acc_m + 14) & 'hFFF;
        exp_q.push_back(acc_m);
        a = 4'd2; b = 4'd7; a_signed = 1'b0; b_signed = 1'b0; accumulate = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("midop_busy", busy, 1);
        tick();
        start = 1'b1; a = 4'd9; b = 4'd15; clear = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midop_done", done, 1);
        pop_check("midop_out", out);
        check("midop_const", out, 'h01D);
        clear = 1'b0;
        tick();
        check("midop_done_fall", done, 0);
        check("midop_no_restart", busy, 0);
        repeat (5) tick();
        check("midop_still_idle", busy, 0);
        check("midop_out_held", out, 'h01D);

        // Back-to-back: start held high through the done cycle.
        a = 4'd4; b = 4'd4; accumulate = 1'b0; start = 1'b1;
        acc_m = 16;
        exp_q.push_back(acc_m);
        tick();
        check("b2b_busy1", busy, 1);
        repeat (3) tick();
        tick();
        check("b2b_done1", done, 1);
        check("b2b_idle_in_done", busy, 0);
        pop_check("b2b_out1", out);
        a = 4'd3; b = 4'd3;
        acc_m = 9;
        exp_q.push_back(acc_m);
        tick();
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        check("b2b_done_fell", done, 0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("b2b_latency2", n, 4);
        pop_check("b2b_out2", out);

        // Truncating instance; clear also zeroes u_mac while it is idle.
        acc_m = 0;
        a = 4'd15; b = 4'd15; a_signed = 1'b0; b_signed = 1'b0;
        accumulate = 1'b0; clear = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0; clear = 1'b0;
        check("trunc_busy", busy2, 1);
        check("trunc_main_cleared", out, 0);
        n = 0;
        while (!done2 && n < 20) begin
            tick();
            n++;
        end
        check("trunc_latency", n, 4);
        check("trunc_out", out2, 56);

        // Reset mid-op.
        run_op(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset");
        a = 4'd5; b = 4'd5; start = 1'b1;
        exp_q.push_back(25);
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_out", out, 0);
        exp_q.delete();
        acc_m = 0;
        tick();
        reset = 1'b0;
        done_seen = 0;
        repeat (8) begin
            tick();
            if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        check("rst_idle", busy, 0);
        run_op(4'd6, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_6x7");
        check("post_reset_const", out, 42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_mac.md
# serial_mac

Parametrised shift-and-add serial multiply-accumulate unit. It is the successor to the fixed 4-bit serial multiplier and is used wherever area matters more than throughput. It supports configurable operand widths, per-operand signedness selected at run time, an accumulating mode with guard bits, and a configurable output truncation shift. It processes one multiplier bit per clock and uses a start/busy/done handshake.

## Interface
Parameters:
- A_WIDTH, 8, multiplicand width (>=2)
- B_WIDTH, 8, multiplier width (>=2); equals the number of compute cycles
- GUARD, 4, accumulator guard bits
- OUT_SHIFT, 0, LSBs dropped from the accumulator at the output (0 <= OUT_SHIFT < ACC_WIDTH)
- Derived localparams: ACC_WIDTH = A_WIDTH+B_WIDTH+GUARD; OUT_WIDTH = ACC_WIDTH-OUT_SHIFT

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request a new operation; sampled only in IDLE
- a  in  A_WIDTH  multiplicand; sampled with start
- b  in  B_WIDTH  multiplier; sampled with start
- a_signed  in  1  a is two's complement; sampled with start
- b_signed  in  1  b is two's complement; sampled with start
- accumulate  in  1  1: acc <= acc + product; 0: acc <= product; sampled with start
- clear  in  1  zero the accumulator; acted on only in IDLE
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when a result is written
- out  out  OUT_WIDTH  acc[ACC_WIDTH-1:OUT_SHIFT]

## Operation
- States: IDLE and RUN. busy = (state==RUN), registered.
- IDLE, start=1: latch a, b, a_signed, b_signed, accumulate; clear partial product and bit counter; go to RUN.
- IDLE, clear=1: acc <= 0. If start is also 1, the accepted operation sees acc=0, so an accumulating op returns the bare product.
- RUN, bit i (i = 0..B_WIDTH-1):
  - a_ext = a extended to ACC_WIDTH: sign-extended if a_signed, else zero-extended.
  - If b[i]=1: pp <= pp + (a_ext << i), except that for i = B_WIDTH-1 with b_signed, pp <= pp - (a_ext << i).
- After the last bit:
  - acc <= (accumulate ? acc : 0) + pp_final, modulo 2^ACC_WIDTH.
  - Pulse done; return to IDLE.
- The product is exact for all four signedness combinations. It is interpreted as signed when either operand is signed and is correctly sign-extended into the guard bits.
- Accumulator overflow wraps silently; no saturation and no flag.
- start, clear and operand changes while busy=1 are ignored. Latched operands are immune to input changes after acceptance.
- out is driven combinationally from acc, so it changes only when acc is written: end of an op, clear, or reset.

## Timing
- Reset values: busy=0, done=0, out=0, acc=0, state=IDLE. Reset takes effect immediately, including mid-operation; the in-flight op is discarded with no done pulse.
- Let E0 be the edge that samples start=1 in IDLE.
  - busy=1 after E0.
  - Bits are processed at edges E1..E_B (B = B_WIDTH).
  - At E_B: acc/out are updated, done=1 and busy=0, all simultaneously.
  - done falls at E_B+1.
- Latency from the start edge to the result is B_WIDTH edges. The state is IDLE during the done cycle, so start may be held or reasserted there and is accepted at E_B+1. Back-to-back throughput is one op per B_WIDTH+1 cycles.
- clear has no effect during RUN, including at the E_B edge.

## Test plan
Bench instance is A_WIDTH=4, B_WIDTH=4, GUARD=4 (ACC_WIDTH=12) unless stated.
- Unsigned 15*15, accumulate=0 -> done exactly 4 edges after the start edge; out=225 (0x0E1); busy high for exactly 4 cycles. Also sweep all 256 unsigned pairs: out == a*b.
- Signed: -8*-8 -> 64 (0x040); -8*7 -> -56 (0xFC8); -1*-1 -> 1. Sweep all 256 signed pairs against the reference product.
- Mixed sign: a=15 unsigned, b=-1 signed -> -15 (0xFF1); a=-8 signed, b=15 unsigned -> -120 (0xF88).
- Accumulate and handshake:
  - clear+start with 3*5, accumulate=1 -> 15.
  - Next op 2*7, accumulate=1 -> 29.
  - start pulsed mid-op with a=9 is ignored, and the result stays 29.
  - Back-to-back start held high through the done cycle -> the second op is accepted at E_B+1.
- Truncation: OUT_SHIFT=2 instance (OUT_WIDTH=10), 15*15 -> out=56.
- Reset mid-op: assert reset 2 cycles after start -> busy=0, done=0, out=0 immediately, and no done pulse follows. After release, 6*7 -> 42 with the correct latency.
